// File: rtl/serial_addsub_ctrl_if.sv
// Handshake and operand/result bundle between the operand source/consumer and
// the bit-serial add/subtract controller.
interface serial_addsub_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ack;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op, a, b, ack,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op, a, b, ack,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one full-adder step per clock over WIDTH-bit
// operands, with a start/busy/done/ack handshake.
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input logic                  clk,
    input logic                  reset,
    serial_addsub_ctrl_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic             bit_a;
    logic             bit_b;
    logic             s_bit;
    logic             c_next;

    // The single shared full-adder cell.
    always_comb begin
        bit_a  = a_q[idx];
        bit_b  = b_q[idx];
        s_bit  = bit_a ^ bit_b ^ carry;
        c_next = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1: invert b and seed the carry with op.
                        a_q    <= bus.a;
                        b_q    <= bus.op ? ~bus.b : bus.b;
                        carry  <= bus.op;
                        idx    <= '0;
                        sum_q  <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx] <= s_bit;
                    carry      <= c_next;
                    idx        <= idx + IDX_W'(1);
                    if (idx == IDX_W'(WIDTH - 1)) begin
                        ovf_q  <= carry ^ c_next;
                        cout_q <= c_next;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
